// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// Frame byte order: LEN_HI, LEN_LO (big-endian word count N), then 4*N data
// bytes with each word big-endian (first byte lands in [31:24]), then one
// checksum byte equal to the XOR of all data bytes (length bytes excluded).
package loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN_HI,
        ST_LEN_LO,
        ST_DATA,
        ST_CHK,
        ST_DONE,
        ST_ERR
    } state_t;

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_LENGTH   = 2'd1;
    localparam logic [1:0] ERR_CHECKSUM = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT  = 2'd3;

    // States in which the loader consumes stream bytes.
    function automatic logic is_loading(input state_t s);
        return (s == ST_LEN_HI) || (s == ST_LEN_LO) || (s == ST_DATA) || (s == ST_CHK);
    endfunction

endpackage

// File: rtl/imem_loader_word_packer.sv
// Collects four stream bytes (big-endian) into one 32-bit word and emits it
// with a single-cycle valid pulse the cycle after the fourth byte arrives.
module imem_word_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        byte_en,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        word_valid
);

    logic [1:0]  byte_cnt;
    logic [23:0] shift;

    // Byte position counter, partial-word shift register and word output.
    always_ff @(posedge clk) begin
        if (rst) begin
            byte_cnt   <= '0;
            shift      <= '0;
            word       <= '0;
            word_valid <= 1'b0;
        end else begin
            word_valid <= 1'b0;
            if (clear) begin
                byte_cnt <= '0;
                shift    <= '0;
            end else if (byte_en) begin
                byte_cnt <= byte_cnt + 2'd1;
                shift    <= {shift[15:0], byte_in};
                if (byte_cnt == 2'd3) begin
                    word       <= {shift, byte_in};
                    word_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory loader: parses a length/data/checksum byte frame from the
// host link, writes words into the IM write port and holds the CPU until a
// complete image with a matching checksum has been written.
module imem_loader
    import loader_pkg::*;
#(
    parameter int unsigned MAX_WORDS = 256,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned TIMEOUT   = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic        byte_ready,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        cpu_hold,
    output logic        done,
    output logic        error,
    output logic [1:0]  err_code,
    output logic [15:0] words_loaded
);

    state_t      state;
    state_t      state_next;
    logic [1:0]  err_next;

    logic        xfer;
    logic        data_xfer;
    logic        enter_load;
    logic        timed_out;

    logic [7:0]  len_hi;
    logic [15:0] len_cat;
    logic [15:0] n_words;
    logic [17:0] data_cnt;
    logic [17:0] last_idx;
    logic [7:0]  csum;
    logic [31:0] idle_cnt;

    assign xfer       = byte_valid & byte_ready;
    assign data_xfer  = xfer && (state == ST_DATA);
    assign len_cat    = {len_hi, byte_in};
    assign last_idx   = {n_words, 2'b00} - 18'd1;
    assign enter_load = (state_next == ST_LEN_HI) && (state != ST_LEN_HI);
    // A byte accepted in the same cycle the limit is reached still counts as progress.
    assign timed_out  = (TIMEOUT != 0) && (idle_cnt == TIMEOUT) && !xfer;

    imem_word_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .clear      (enter_load),
        .byte_en    (data_xfer),
        .byte_in    (byte_in),
        .word       (imem_wdata),
        .word_valid (imem_we)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and the error code attached to each ERR entry.
    always_comb begin
        state_next = state;
        err_next   = ERR_NONE;
        case (state)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) state_next = ST_LEN_HI;
            end
            ST_LEN_HI: begin
                if (xfer) state_next = ST_LEN_LO;
            end
            ST_LEN_LO: begin
                if (xfer) begin
                    if (len_cat == 16'd0) begin
                        state_next = ST_CHK;
                    end else if (32'(len_cat) > MAX_WORDS) begin
                        state_next = ST_ERR;
                        err_next   = ERR_LENGTH;
                    end else begin
                        state_next = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (xfer && (data_cnt == last_idx)) state_next = ST_CHK;
            end
            ST_CHK: begin
                if (xfer) begin
                    if (byte_in == csum) begin
                        state_next = ST_DONE;
                    end else begin
                        state_next = ST_ERR;
                        err_next   = ERR_CHECKSUM;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
        if (is_loading(state) && timed_out) begin
            state_next = ST_ERR;
            err_next   = ERR_TIMEOUT;
        end
    end

    // Registered status outputs, derived from the state being entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            byte_ready <= 1'b0;
            cpu_hold   <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
            err_code   <= ERR_NONE;
        end else begin
            byte_ready <= is_loading(state_next);
            cpu_hold   <= (state_next != ST_DONE);
            done       <= (state_next == ST_DONE);
            error      <= (state_next == ST_ERR);
            if (enter_load) begin
                err_code <= ERR_NONE;
            end else if ((state_next == ST_ERR) && (state != ST_ERR)) begin
                err_code <= err_next;
            end
        end
    end

    // Frame bookkeeping: length capture, data byte count and running checksum.
    always_ff @(posedge clk) begin
        if (rst) begin
            len_hi   <= '0;
            n_words  <= '0;
            data_cnt <= '0;
            csum     <= '0;
        end else if (enter_load) begin
            n_words  <= '0;
            data_cnt <= '0;
            csum     <= '0;
        end else begin
            if (xfer && (state == ST_LEN_HI)) len_hi <= byte_in;
            if (xfer && (state == ST_LEN_LO)) n_words <= len_cat;
            if (data_xfer) begin
                data_cnt <= data_cnt + 18'd1;
                csum     <= csum ^ byte_in;
            end
        end
    end

    // Idle-cycle counter between accepted bytes while loading.
    always_ff @(posedge clk) begin
        if (rst) begin
            idle_cnt <= '0;
        end else if (enter_load || xfer || !is_loading(state)) begin
            idle_cnt <= '0;
        end else if (TIMEOUT != 0) begin
            idle_cnt <= idle_cnt + 32'd1;
        end
    end

    // Write address advances after each strobe; word count steps with the strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            imem_addr    <= BASE_ADDR;
            words_loaded <= '0;
        end else if (enter_load) begin
            imem_addr    <= BASE_ADDR;
            words_loaded <= '0;
        end else begin
            if (imem_we) imem_addr <= imem_addr + 32'd4;
            if (data_xfer && (data_cnt[1:0] == 2'b11)) words_loaded <= words_loaded + 16'd1;
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: frame parsing, IM writes, checksum, length
// limit, timeout, back-to-back streaming and mid-load reset.
module tb_imem_loader;

    localparam logic [31:0] BASE = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_hold;
    logic        done;
    logic        error;
    logic [1:0]  err_code;
    logic [15:0] words_loaded;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int last_xfer_cyc = 0;

    logic [31:0] wr_addr[$];
    logic [31:0] wr_data[$];
    int          wr_cyc[$];
    logic [7:0]  tx_q[$];

    imem_loader #(
        .MAX_WORDS (4),
        .BASE_ADDR (BASE),
        .TIMEOUT   (16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .byte_in      (byte_in),
        .byte_valid   (byte_valid),
        .byte_ready   (byte_ready),
        .imem_we      (imem_we),
        .imem_addr    (imem_addr),
        .imem_wdata   (imem_wdata),
        .cpu_hold     (cpu_hold),
        .done         (done),
        .error        (error),
        .err_code     (err_code),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Log every IM write strobe with its cycle number.
    always @(negedge clk) begin
        if (imem_we) begin
            wr_addr.push_back(imem_addr);
            wr_data.push_back(imem_wdata);
            wr_cyc.push_back(cyc);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic clear_log();
        wr_addr.delete();
        wr_data.delete();
        wr_cyc.delete();
    endtask

    task automatic check_write(input string tag, input int idx, input logic [31:0] a, input logic [31:0] d);
        if (idx < wr_addr.size()) begin
            check({tag, "_addr"}, wr_addr[idx], a);
            check({tag, "_data"}, wr_data[idx], d);
        end else begin
            check({tag, "_present"}, wr_addr.size(), idx + 1);
        end
    endtask

    task automatic check_reset(input string p);
        check({p, "_ready"}, 32'(byte_ready), 32'd0);
        check({p, "_we"},    32'(imem_we),    32'd0);
        check({p, "_addr"},  imem_addr,       BASE);
        check({p, "_wdata"}, imem_wdata,      32'd0);
        check({p, "_hold"},  32'(cpu_hold),   32'd1);
        check({p, "_done"},  32'(done),       32'd0);
        check({p, "_error"}, 32'(error),      32'd0);
        check({p, "_code"},  32'(err_code),   32'd0);
        check({p, "_words"}, 32'(words_loaded), 32'd0);
    endtask

    // Offer one byte starting at a falling edge; returns at the falling edge after it is taken.
    task automatic send_byte(input logic [7:0] b);
        int n;
        byte_in    = b;
        byte_valid = 1'b1;
        n = 0;
        while (!byte_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!byte_ready) begin
            check("ready_wait", 32'(byte_ready), 32'd1);
            byte_valid = 1'b0;
        end else begin
            last_xfer_cyc = cyc;
            @(negedge clk);
            byte_valid = 1'b0;
        end
    endtask

    task automatic send_q();
        foreach (tx_q[i]) send_byte(tx_q[i]);
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        int n;
        int c4;
        int c8;

        rst        = 1'b1;
        start      = 1'b0;
        byte_in    = '0;
        byte_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_reset("rst");
        rst = 1'b0;
        @(negedge clk);

        // Two-word image; XOR of the eight data bytes is 0x25.
        clear_log();
        do_start();
        check("t1_ready_after_start", 32'(byte_ready), 32'd1);
        check("t1_hold_loading", 32'(cpu_hold), 32'd1);
        tx_q = {8'h00, 8'h02, 8'h3C, 8'h01, 8'h00, 8'h10, 8'h00, 8'h00, 8'h00, 8'h08, 8'h25};
        send_q();
        @(negedge clk);
        check("t1_done", 32'(done), 32'd1);
        check("t1_hold", 32'(cpu_hold), 32'd0);
        check("t1_error", 32'(error), 32'd0);
        check("t1_ready", 32'(byte_ready), 32'd0);
        check("t1_words", 32'(words_loaded), 32'd2);
        check("t1_nwr", wr_addr.size(), 32'd2);
        check_write("t1_w0", 0, BASE, 32'h3C01_0010);
        check_write("t1_w1", 1, BASE + 32'd4, 32'h0000_0008);

        // Empty image: good then bad checksum.
        clear_log();
        do_start();
        check("t2_done_cleared", 32'(done), 32'd0);
        check("t2_hold_set", 32'(cpu_hold), 32'd1);
        tx_q = {8'h00, 8'h00, 8'h00};
        send_q();
        @(negedge clk);
        check("t2_done", 32'(done), 32'd1);
        check("t2_words", 32'(words_loaded), 32'd0);
        check("t2_nwr", wr_addr.size(), 32'd0);
        do_start();
        tx_q = {8'h00, 8'h00, 8'h01};
        send_q();
        @(negedge clk);
        check("t2_error", 32'(error), 32'd1);
        check("t2_code", 32'(err_code), 32'd2);
        check("t2_hold", 32'(cpu_hold), 32'd1);
        check("t2_done_low", 32'(done), 32'd0);
        check("t2_nwr_bad", wr_addr.size(), 32'd0);

        // Length above the limit.
        clear_log();
        do_start();
        check("t3_error_cleared", 32'(error), 32'd0);
        check("t3_code_cleared", 32'(err_code), 32'd0);
        tx_q = {8'h00, 8'h05};
        send_q();
        @(negedge clk);
        check("t3_error", 32'(error), 32'd1);
        check("t3_code", 32'(err_code), 32'd1);
        check("t3_ready", 32'(byte_ready), 32'd0);
        check("t3_nwr", wr_addr.size(), 32'd0);

        // Length exactly at the limit; checksum 01^02^03^04 = 04.
        clear_log();
        do_start();
        tx_q = {8'h00, 8'h04,
                8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h02,
                8'h00, 8'h00, 8'h00, 8'h03, 8'h00, 8'h00, 8'h00, 8'h04, 8'h04};
        send_q();
        @(negedge clk);
        check("t3b_done", 32'(done), 32'd1);
        check("t3b_words", 32'(words_loaded), 32'd4);
        check("t3b_nwr", wr_addr.size(), 32'd4);
        check_write("t3b_w3", 3, BASE + 32'd12, 32'h0000_0004);

        // Stream stalls after the fifth data byte.
        clear_log();
        do_start();
        tx_q = {8'h00, 8'h02, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
        send_q();
        repeat (15) @(negedge clk);
        check("t4_no_early_timeout", 32'(error), 32'd0);
        n = 0;
        while (!error && n < 6) begin
            @(negedge clk);
            n++;
        end
        check("t4_error", 32'(error), 32'd1);
        check("t4_code", 32'(err_code), 32'd3);
        check("t4_words", 32'(words_loaded), 32'd1);
        check("t4_ready", 32'(byte_ready), 32'd0);
        check("t4_nwr", wr_addr.size(), 32'd1);
        check_write("t4_w0", 0, BASE, 32'hAABB_CCDD);

        // Continuous valid; checksum 11^22^...^88 = 0x88.
        clear_log();
        do_start();
        send_byte(8'h00);
        send_byte(8'h02);
        tx_q = {8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        c4 = 0;
        c8 = 0;
        foreach (tx_q[i]) begin
            send_byte(tx_q[i]);
            if (i == 3) c4 = last_xfer_cyc;
            if (i == 7) c8 = last_xfer_cyc;
        end
        send_byte(8'h88);
        @(negedge clk);
        check("t5_gapless", 32'(c8 - c4), 32'd4);
        check("t5_nwr", wr_addr.size(), 32'd2);
        if (wr_cyc.size() == 2) begin
            check("t5_strobe0_cyc", 32'(wr_cyc[0]), 32'(c4 + 1));
            check("t5_strobe1_cyc", 32'(wr_cyc[1]), 32'(c8 + 1));
        end
        check_write("t5_w0", 0, BASE, 32'h1122_3344);
        check_write("t5_w1", 1, BASE + 32'd4, 32'h5566_7788);
        check("t5_done", 32'(done), 32'd1);

        // Reset mid-DATA, then reload.
        clear_log();
        do_start();
        tx_q = {8'h00, 8'h02, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        send_q();
        byte_in    = 8'h07;
        byte_valid = 1'b1;
        rst        = 1'b1;
        @(negedge clk);
        check_reset("t6");
        rst        = 1'b0;
        byte_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("t6_no_more_writes", wr_addr.size(), 32'd1);
        check("t6_idle_ready", 32'(byte_ready), 32'd0);
        clear_log();
        do_start();
        tx_q = {8'h00, 8'h02, 8'h3C, 8'h01, 8'h00, 8'h10, 8'h00, 8'h00, 8'h00, 8'h08, 8'h25};
        send_q();
        @(negedge clk);
        check("t6_done", 32'(done), 32'd1);
        check("t6_nwr", wr_addr.size(), 32'd2);
        check_write("t6_w0", 0, BASE, 32'h3C01_0010);
        check_write("t6_w1", 1, BASE + 32'd4, 32'h0000_0008);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
